// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the BIST initiator (master) and the ALU under test (slave).
interface alu_bist_if;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic        alu_Cin;
    logic [4:0]  alu_Card;
    logic [31:0] alu_F;
    logic        alu_Cout;
    logic        alu_Zero;

    modport master (
        output alu_A, alu_B, alu_Cin, alu_Card,
        input  alu_F, alu_Cout, alu_Zero
    );

    modport slave (
        input  alu_A, alu_B, alu_Cin, alu_Card,
        output alu_F, alu_Cout, alu_Zero
    );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the ALU adder paths (OP_1 / OP_2).
// Define BIST_COUT_CHECK_EN to include alu_Cout in the mismatch decision.
module alu_bist #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [31:0] LFSR_SEED   = 32'hACE12345
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [15:0]       first_fail_vec,
    alu_bist_if.master        alu
);

    localparam logic [4:0]  OP_1      = 5'b00001;
    localparam logic [4:0]  OP_2      = 5'b00010;
    localparam logic [31:0] TAPS      = 32'h80200003;
    localparam logic [31:0] MSB       = 32'h80000000;
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h00000001 : LFSR_SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic        launch_s;
    logic        apply_s;
    logic        check_s;
    logic        fin_s;

    logic [31:0] lfsr_r;
    logic [15:0] idx_r;
    logic        op_sel_r;
    logic [32:0] exp_r;

    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic        alu_cin_r;
    logic [4:0]  alu_card_r;

    logic [31:0] rot_s;
    logic [31:0] rev_s;
    logic [31:0] opa_s;
    logic [31:0] opb_s;
    logic        cin_s;
    logic [4:0]  card_s;
    logic [32:0] exp_s;

    logic        cout_en_s;
    logic        cout_bad_s;
    logic        mismatch_s;

    assign alu.alu_A    = alu_a_r;
    assign alu.alu_B    = alu_b_r;
    assign alu.alu_Cin  = alu_cin_r;
    assign alu.alu_Card = alu_card_r;

`ifdef BIST_COUT_CHECK_EN
    assign cout_en_s = 1'b1;
`else
    assign cout_en_s = 1'b0;
`endif

    assign cout_bad_s = cout_en_s & (alu.alu_Cout != exp_r[32]);
    // The ALU is combinational, so its result is compared against the expectation latched at APPLY.
    assign mismatch_s = (alu.alu_F != exp_r[31:0])
                      | (alu.alu_Zero != (exp_r[31:0] == 32'h0))
                      | cout_bad_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = APPLY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            APPLY: state_nxt_s = CHECK;
            CHECK: begin
                if (!op_sel_r) begin
                    state_nxt_s = APPLY;
                end else if (idx_r == LAST_IDX) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = APPLY;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        launch_s = 1'b0;
        apply_s  = 1'b0;
        check_s  = 1'b0;
        fin_s    = 1'b0;
        case (state_r)
            IDLE:    launch_s = start;
            APPLY:   apply_s  = 1'b1;
            CHECK:   check_s  = 1'b1;
            FIN:     fin_s    = 1'b1;
            default: launch_s = 1'b0;
        endcase
    end

    // Operand classes rotate with the low two bits of the vector index
    always_comb begin
        rot_s = {lfsr_r[15:0], lfsr_r[31:16]} ^ 32'h5A5A5A5A;
        rev_s = bit_rev(lfsr_r);
        case (idx_r[1:0])
            2'd0: begin
                opa_s = lfsr_r;
                opb_s = rot_s;
            end
            2'd1: begin
                opa_s = lfsr_r;
                opb_s = 32'h0;
            end
            2'd2: begin
                opa_s = ~lfsr_r | MSB;
                opb_s = rev_s | MSB;
            end
            2'd3: begin
                opa_s = ~lfsr_r | MSB;
                opb_s = 32'h0;
            end
            default: begin
                opa_s = lfsr_r;
                opb_s = 32'h0;
            end
        endcase
        cin_s  = idx_r[0];
        card_s = op_sel_r ? OP_2 : OP_1;
        exp_s  = {1'b0, opa_s} + {1'b0, opb_s} + {32'h0, cin_s & op_sel_r};
    end

    // Sequencing state: LFSR, vector index and op select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r   <= SEED_EFF;
            idx_r    <= 16'h0;
            op_sel_r <= 1'b0;
        end else if (launch_s) begin
            lfsr_r   <= SEED_EFF;
            idx_r    <= 16'h0;
            op_sel_r <= 1'b0;
        end else if (check_s) begin
            op_sel_r <= ~op_sel_r;
            if (op_sel_r) begin
                lfsr_r <= lfsr_step(lfsr_r);
                idx_r  <= idx_r + 16'd1;
            end
        end
    end

    // Registered ALU drive and expected sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r    <= 32'h0;
            alu_b_r    <= 32'h0;
            alu_cin_r  <= 1'b0;
            alu_card_r <= 5'b00000;
            exp_r      <= 33'h0;
        end else if (apply_s) begin
            alu_a_r    <= opa_s;
            alu_b_r    <= opb_s;
            alu_cin_r  <= cin_s;
            alu_card_r <= card_s;
            exp_r      <= exp_s;
        end
    end

    // Status outputs; err_count==0 doubles as the "no mismatch yet" marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'h0;
            first_fail_vec <= 16'hFFFF;
        end else begin
            done <= fin_s;
            if (launch_s) begin
                busy           <= 1'b1;
                pass           <= 1'b0;
                err_count      <= 16'h0;
                first_fail_vec <= 16'hFFFF;
            end else if (check_s && mismatch_s) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'h0) begin
                    first_fail_vec <= idx_r;
                end
            end else if (fin_s) begin
                busy <= 1'b0;
                pass <= (err_count == 16'h0);
            end
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: behavioural ALU with fault injection and a vector-table reference model.
module tb_alu_bist;

    localparam int          NV   = 4;
    localparam int          NA   = 2 * NV;
    localparam logic [31:0] SEED = 32'h0100001C;  // LFSR reaches 32'h80000000 at vector 3

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [4:0]  card;
    } op_t;

    typedef struct {
        logic [15:0] err;
        logic [15:0] ffv;
        logic        pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count, first_fail_vec;

    int checks = 0;
    int errors = 0;

    op_t         tab[NA];
    bit          fault_en[NA];
    logic [4:0]  fault_bit[NA];
    bit          cout_bad = 1'b0;
    op_t         ops_q[$];
    res_t        res_q[$];

    logic [32:0] alu_sum;
    logic [31:0] alu_fval;

    alu_bist_if bus ();

    alu_bist #(.NUM_VECTORS(NV), .LFSR_SEED(SEED)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .alu            (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU, corrupting F for selected (operand, opcode) tuples
    always_comb begin
        alu_sum = {1'b0, bus.alu_A} + {1'b0, bus.alu_B}
                + ((bus.alu_Card == 5'b00010) ? {32'h0, bus.alu_Cin} : 33'h0);
        alu_fval = alu_sum[31:0];
        for (int i = 0; i < NA; i++) begin
            if (fault_en[i] && bus.alu_A == tab[i].a && bus.alu_B == tab[i].b &&
                bus.alu_Cin == tab[i].cin && bus.alu_Card == tab[i].card) begin
                alu_fval = alu_fval ^ (32'h1 << fault_bit[i]);
            end
        end
        bus.alu_F    = alu_fval;
        bus.alu_Zero = (alu_sum[31:0] == 32'h0);
        bus.alu_Cout = alu_sum[32] ^ cout_bad;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: operand/opcode sequence of a whole run, straight from the vector rules
    task automatic build_tab();
        logic [31:0] l;
        logic [31:0] a, b, rev;
        l = (SEED == 32'h0) ? 32'h1 : SEED;
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 32; k++) rev[k] = l[31 - k];
            case (v % 4)
                0:       begin a = l;                b = ((l << 16) | (l >> 16)) ^ 32'h5A5A5A5A; end
                1:       begin a = l;                b = 32'h0; end
                2:       begin a = ~l | 32'h80000000; b = rev | 32'h80000000; end
                default: begin a = ~l | 32'h80000000; b = 32'h0; end
            endcase
            for (int op = 0; op < 2; op++) begin
                tab[2 * v + op].a    = a;
                tab[2 * v + op].b    = b;
                tab[2 * v + op].cin  = v[0];
                tab[2 * v + op].card = (op == 0) ? 5'b00001 : 5'b00010;
            end
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        end
    endtask

    function automatic res_t predict();
        res_t r;
        bit   cout_hit;
`ifdef BIST_COUT_CHECK_EN
        cout_hit = cout_bad;
`else
        cout_hit = 1'b0;
`endif
        r.err = 16'h0;
        r.ffv = 16'hFFFF;
        for (int i = 0; i < NA; i++) begin
            if (fault_en[i] || cout_hit) begin
                if (r.err == 16'h0) r.ffv = 16'(i / 2);
                r.err = r.err + 16'd1;
            end
        end
        r.pass = (r.err == 16'h0);
        return r;
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < NA; i++) begin
            fault_en[i]  = 1'b0;
            fault_bit[i] = 5'd0;
        end
        cout_bad = 1'b0;
    endtask

    task automatic push_expect(output res_t r);
        for (int i = 0; i < NA; i++) ops_q.push_back(tab[i]);
        r = predict();
        res_q.push_back(r);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done not seen within 200 cycles", name);
        end
    endtask

    task automatic run(input string name, input bit hold);
        res_t r;
        push_expect(r);
        @(negedge clk);
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(name);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_pass_held"}, 64'(pass), 64'(r.pass));
        chk({name, "_idle"}, 64'(busy), 64'h0);
    endtask

    // Monitor: checks each new ALU drive and each completion against the scoreboard
    initial begin
        logic [4:0] prev_card = 5'b00000;
        int         busy_cnt = 0;
        op_t        o;
        res_t       r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_card = 5'b00000;
                busy_cnt  = 0;
            end else begin
                if (busy) busy_cnt++;
                if (bus.alu_Card != prev_card) begin
                    prev_card = bus.alu_Card;
                    if (ops_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL apply: unexpected ALU drive card=%0h", bus.alu_Card);
                    end else begin
                        o = ops_q.pop_front();
                        chk("apply_tuple", {bus.alu_A, bus.alu_B[26:0], bus.alu_Cin, bus.alu_Card},
                            {o.a, o.b[26:0], o.cin, o.card});
                        chk("apply_b_hi", 64'(bus.alu_B[31:27]), 64'(o.b[31:27]));
                    end
                end
                if (done) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done: unexpected completion pulse");
                    end else begin
                        r = res_q.pop_front();
                        chk("err_count", 64'(err_count), 64'(r.err));
                        chk("first_fail_vec", 64'(first_fail_vec), 64'(r.ffv));
                        chk("pass", 64'(pass), 64'(r.pass));
                        chk("busy_cycles", 64'(busy_cnt), 64'(4 * NV + 1));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t r;
        clear_faults();
        build_tab();
        #12;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_pass", 64'(pass), 64'h0);
        chk("rst_err", 64'(err_count), 64'h0);
        chk("rst_ffv", 64'(first_fail_vec), 64'hFFFF);
        chk("rst_alu", {bus.alu_A, bus.alu_B}, 64'h0);
        chk("rst_card", {bus.alu_Cin, bus.alu_Card}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("golden", 1'b0);

        fault_en[4] = 1'b1;
        fault_en[5] = 1'b1;
        run("vec2_bit0", 1'b0);

        clear_faults();
        cout_bad = 1'b1;
        run("cout_forced", 1'b0);

        for (int n = 0; n < 6; n++) begin
            clear_faults();
            for (int i = 0; i < NA; i++) begin
                fault_en[i]  = ($urandom_range(0, 3) == 0);
                fault_bit[i] = 5'($urandom_range(0, 31));
            end
            run("random", 1'b0);
        end

        clear_faults();
        fault_en[0] = 1'b1;
        push_expect(r);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        chk("midrst_alu", {bus.alu_A, bus.alu_B}, 64'h0);
        chk("midrst_card", {bus.alu_Cin, bus.alu_Card}, 64'h0);
        chk("midrst_err", 64'(err_count), 64'h0);
        ops_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_faults();
        run("after_reset", 1'b0);

        run("start_held", 1'b1);
        chk("held_no_rerun", 64'(ops_q.size() + res_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
